alu_issuer: RTL and testbench

ALU_ISSUER -- requirements
Module: alu_issuer

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_issuer_if.sv | 30 +++
 rtl/alu_latency_counter.sv | 29 ++
 rtl/alu_issuer.sv | 119 +++++++++++
 tb/tb_alu_issuer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU issuer: FSM states, unit select
// encodings and the logical-unit sub-operation codes.
package alu_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   localparam logic UNIT_LOGIC = 1'b0;
   localparam logic UNIT_ARITH = 1'b1;

   typedef enum logic [2:0] {
      LOP_AND  = 3'b000,
      LOP_OR   = 3'b001,
      LOP_XOR  = 3'b010,
      LOP_NOR  = 3'b011,
      LOP_NAND = 3'b100,
      LOP_XNOR = 3'b101,
      LOP_GT   = 3'b110,
      LOP_EQ   = 3'b111
   } lop_t;

   localparam int CNT_W = 3;

endpackage

// File: rtl/alu_issuer_if.sv
// Request and result handshake bundle between a requester/consumer
// (master) and the ALU issuer (slave).
interface alu_issuer_if #(
   parameter int N = 4,
   parameter int M = 4
) ();

   logic         in_valid;
   logic         in_ready;
   logic [M-1:0] in_opcode;
   logic [N-1:0] in_a;
   logic [N-1:0] in_b;

   logic         res_valid;
   logic         res_ready;
   logic [N-1:0] res_data;
   logic         res_zero;
   logic         res_ones;

   modport master (
      output in_valid, in_opcode, in_a, in_b, res_ready,
      input  in_ready, res_valid, res_data, res_zero, res_ones
   );

   modport slave (
      input  in_valid, in_opcode, in_a, in_b, res_ready,
      output in_ready, res_valid, res_data, res_zero, res_ones
   );

endinterface

// File: rtl/alu_latency_counter.sv
// Down-counter tracking execution-unit latency: load, decrement,
// and a flag marking the final cycle of the wait.
module alu_latency_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic         i_dec,
   input  logic [W-1:0] i_val,
   output logic         o_last
);

   logic [W-1:0] r_cnt;

   // Load wins over decrement; the count never wraps below zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_last = (r_cnt == W'(1));

endmodule

// File: rtl/alu_issuer.sv
// Single-outstanding ALU issuer: latches a request, drives both
// units, waits LAT cycles and holds the selected result until taken.
module alu_issuer
   import alu_pkg::*;
#(
   parameter int N   = 4,
   parameter int M   = 4,
   parameter int LAT = 1
) (
   input  logic           clk,
   input  logic           rst,
   alu_issuer_if.slave    bus,
   output logic [N-1:0]   alu_a,
   output logic [N-1:0]   alu_b,
   output logic [M-2:0]   alu_instruction,
   output logic           alu_unit,
   input  logic [N-1:0]   log_out,
   input  logic [N-1:0]   arith_out,
   output logic [7:0]     op_count
);

   state_t       r_state;
   logic         r_in_ready;
   logic         r_res_valid;
   logic         r_res_zero;
   logic         r_res_ones;
   logic         r_unit;
   logic [N-1:0] r_a;
   logic [N-1:0] r_b;
   logic [N-1:0] r_data;
   logic [M-2:0] r_instr;
   logic [7:0]   r_count;

   logic         w_load;
   logic         w_dec;
   logic         w_last;
   logic [N-1:0] w_sel;

   assign w_load = (r_state == S_ISSUE);
   assign w_dec  = (r_state == S_WAIT);
   assign w_sel  = (r_unit == UNIT_ARITH) ? arith_out : log_out;

   alu_latency_counter #(
      .W (CNT_W)
   ) u_lat (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load),
      .i_dec  (w_dec),
      .i_val  (CNT_W'(LAT)),
      .o_last (w_last)
   );

   // Issue FSM with all handshake, operand and result outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_res_valid <= 1'b0;
         r_res_zero  <= 1'b0;
         r_res_ones  <= 1'b0;
         r_unit      <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_data      <= '0;
         r_instr     <= '0;
         r_count     <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_a        <= bus.in_a;
                  r_b        <= bus.in_b;
                  r_unit     <= bus.in_opcode[M-1];
                  r_instr    <= bus.in_opcode[M-2:0];
                  r_in_ready <= 1'b0;
                  r_state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (w_last) begin
                  r_data      <= w_sel;
                  r_res_zero  <= (w_sel == '0);
                  r_res_ones  <= &w_sel;
                  r_res_valid <= 1'b1;
                  r_state     <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (bus.res_ready) begin
                  r_res_valid <= 1'b0;
                  r_count     <= r_count + 8'd1;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.res_valid = r_res_valid;
   assign bus.res_data  = r_data;
   assign bus.res_zero  = r_res_zero;
   assign bus.res_ones  = r_res_ones;

   assign alu_a           = r_a;
   assign alu_b           = r_b;
   assign alu_instruction = r_instr;
   assign alu_unit        = r_unit;
   assign op_count        = r_count;

endmodule

// File: tb/tb_alu_issuer.sv
// Directed bench for alu_issuer with registered logical and
// arithmetic unit models on the unit-facing ports.
module tb_alu_issuer;
   import alu_pkg::*;

   localparam int N   = 4;
   localparam int M   = 4;
   localparam int LAT = 1;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   alu_issuer_if #(.N(N), .M(M)) bus ();

   logic [N-1:0] alu_a;
   logic [N-1:0] alu_b;
   logic [M-2:0] alu_instruction;
   logic         alu_unit;
   logic [N-1:0] log_out;
   logic [N-1:0] arith_out;
   logic [7:0]   op_count;

   logic         force_en;
   logic [N-1:0] force_log;
   logic [N-1:0] force_arith;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   alu_issuer #(.N(N), .M(M), .LAT(LAT)) dut (
      .clk             (clk),
      .rst             (rst),
      .bus             (bus),
      .alu_a           (alu_a),
      .alu_b           (alu_b),
      .alu_instruction (alu_instruction),
      .alu_unit        (alu_unit),
      .log_out         (log_out),
      .arith_out       (arith_out),
      .op_count        (op_count)
   );

   function automatic logic [N-1:0] lmodel(input logic [2:0] op,
                                           input logic [N-1:0] a,
                                           input logic [N-1:0] b);
      logic [N-1:0] r;
      r = '0;
      case (op)
         LOP_AND:  r = a & b;
         LOP_OR:   r = a | b;
         LOP_XOR:  r = a ^ b;
         LOP_NOR:  r = ~(a | b);
         LOP_NAND: r = ~(a & b);
         LOP_XNOR: r = ~(a ^ b);
         LOP_GT:   r = (a > b) ? '1 : '0;
         LOP_EQ:   r = (a == b) ? '1 : '0;
         default:  r = '0;
      endcase
      return r;
   endfunction

   // Registered unit models, one cycle of latency.
   always @(posedge clk) begin
      log_out   <= force_en ? force_log
                            : lmodel(alu_instruction, alu_a, alu_b);
      arith_out <= force_en ? force_arith : alu_a + alu_b;
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_op(input string tag,
                        input logic [3:0] opc,
                        input logic [3:0] a,
                        input logic [3:0] b,
                        input logic [3:0] ed,
                        input logic ez,
                        input logic eo);
      bus.in_valid  = 1'b1;
      bus.in_opcode = opc;
      bus.in_a      = a;
      bus.in_b      = b;
      tick;
      bus.in_valid  = 1'b0;
      bus.in_opcode = ~opc;
      bus.in_a      = ~a;
      chk({tag, ".busy"}, 32'(bus.in_ready), 32'd0);
      chk({tag, ".alu_a"}, 32'(alu_a), 32'(a));
      chk({tag, ".alu_b"}, 32'(alu_b), 32'(b));
      chk({tag, ".instr"}, 32'(alu_instruction), 32'(opc[2:0]));
      chk({tag, ".unit"}, 32'(alu_unit), 32'(opc[3]));
      tick;
      chk({tag, ".early"}, 32'(bus.res_valid), 32'd0);
      tick;
      chk({tag, ".valid"}, 32'(bus.res_valid), 32'd1);
      chk({tag, ".data"}, 32'(bus.res_data), 32'(ed));
      chk({tag, ".zero"}, 32'(bus.res_zero), 32'(ez));
      chk({tag, ".ones"}, 32'(bus.res_ones), 32'(eo));
   endtask

   task automatic take(input string tag, input logic [7:0] ecnt);
      bus.res_ready = 1'b1;
      tick;
      bus.res_ready = 1'b0;
      chk({tag, ".rv_low"}, 32'(bus.res_valid), 32'd0);
      chk({tag, ".rdy"}, 32'(bus.in_ready), 32'd1);
      chk({tag, ".cnt"}, 32'(op_count), 32'(ecnt));
   endtask

   initial begin
      int prev;
      int n;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_opcode = '0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.res_ready = 1'b0;
      force_en      = 1'b0;
      force_log     = '0;
      force_arith   = '0;
      prev          = 0;
      tick;
      tick;
      tick;
      rst = 1'b0;
      tick;

      chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst.res_valid", 32'(bus.res_valid), 32'd0);
      chk("rst.res_data", 32'(bus.res_data), 32'd0);
      chk("rst.res_zero", 32'(bus.res_zero), 32'd0);
      chk("rst.res_ones", 32'(bus.res_ones), 32'd0);
      chk("rst.alu_a", 32'(alu_a), 32'd0);
      chk("rst.alu_b", 32'(alu_b), 32'd0);
      chk("rst.instr", 32'(alu_instruction), 32'd0);
      chk("rst.unit", 32'(alu_unit), 32'd0);
      chk("rst.op_count", 32'(op_count), 32'd0);

      do_op("xor", 4'b0010, 4'b0101, 4'b0011, 4'b0110, 1'b0, 1'b0);
      take("xor", 8'd1);
      do_op("gt", 4'b0110, 4'b1001, 4'b0011, 4'b1111, 1'b0, 1'b1);
      take("gt", 8'd2);
      do_op("and", 4'b0000, 4'b1010, 4'b0101, 4'b0000, 1'b1, 1'b0);
      take("and", 8'd3);

      do_op("nor", 4'b0011, 4'b0101, 4'b0011, 4'b1000, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = (i % 2 == 0);
         bus.in_a     = 4'(i + 7);
         tick;
         chk("hold.data", 32'(bus.res_data), 32'h8);
         chk("hold.valid", 32'(bus.res_valid), 32'd1);
         chk("hold.busy", 32'(bus.in_ready), 32'd0);
         chk("hold.cnt", 32'(op_count), 32'd3);
      end
      bus.in_valid = 1'b0;
      take("nor", 8'd4);

      force_en    = 1'b1;
      force_log   = 4'b0011;
      force_arith = 4'b1100;
      do_op("sel_ar", 4'b1000, 4'b0001, 4'b0010, 4'b1100, 1'b0, 1'b0);
      take("sel_ar", 8'd5);
      do_op("sel_lg", 4'b0101, 4'b0001, 4'b0010, 4'b0011, 1'b0, 1'b0);
      take("sel_lg", 8'd6);
      force_en = 1'b0;
      do_op("add", 4'b1001, 4'b0111, 4'b0110, 4'b1101, 1'b0, 1'b0);
      take("add", 8'd7);
      do_op("eq", 4'b0111, 4'b1010, 4'b1010, 4'b1111, 1'b0, 1'b1);
      take("eq", 8'd8);

      bus.in_valid  = 1'b1;
      bus.in_opcode = 4'b0001;
      bus.in_a      = 4'b0101;
      bus.in_b      = 4'b1010;
      tick;
      bus.in_valid = 1'b0;
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("rw.valid", 32'(bus.res_valid), 32'd0);
      chk("rw.data", 32'(bus.res_data), 32'd0);
      chk("rw.ones", 32'(bus.res_ones), 32'd0);
      chk("rw.cnt", 32'(op_count), 32'd0);
      chk("rw.rdy", 32'(bus.in_ready), 32'd1);
      tick;
      tick;
      chk("rw.no_res", 32'(bus.res_valid), 32'd0);

      rst           = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_a      = 4'b1111;
      bus.res_ready = 1'b1;
      tick;
      rst           = 1'b0;
      bus.in_valid  = 1'b0;
      bus.res_ready = 1'b0;
      chk("rprio.alu_a", 32'(alu_a), 32'd0);
      chk("rprio.rdy", 32'(bus.in_ready), 32'd1);

      bus.res_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_opcode = 4'b0000;
      for (int k = 0; k < 256; k++) begin
         bus.in_a = 4'(k);
         bus.in_b = 4'(k + 3);
         n = 0;
         while (bus.in_ready !== 1'b1 && n < 8) begin
            tick;
            n++;
         end
         chk("b2b.rdy", 32'(bus.in_ready), 32'd1);
         tick;
         if (k > 0) chk("b2b.space", 32'(cyc - prev), 32'd4);
         prev = cyc;
      end
      bus.in_valid = 1'b0;
      n = 0;
      while (bus.res_valid !== 1'b1 && n < 8) begin
         tick;
         n++;
      end
      chk("b2b.last_rv", 32'(bus.res_valid), 32'd1);
      chk("b2b.cnt255", 32'(op_count), 32'd255);
      tick;
      bus.res_ready = 1'b0;
      chk("b2b.wrap", 32'(op_count), 32'd0);
      chk("b2b.rdy_end", 32'(bus.in_ready), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
